// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF   = 100_000_000;
  localparam int unsigned BAUD_DEF       = 9600;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS      = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // Clocks per oversample tick (integer floor).
  function automatic int unsigned tick_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received byte and status out.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 rx_busy;
  logic                 frame_err;

  // Line/consumer side.
  modport master (
    output rx,
    input  rx_data,
    input  rx_done,
    input  rx_busy,
    input  frame_err
  );

  // Receiver side.
  modport slave (
    input  rx,
    output rx_data,
    output rx_done,
    output rx_busy,
    output frame_err
  );
endinterface

// File: rtl/baud_tick_gen.sv
// One-cycle tick every CLK_FREQ/(BAUD*OVERSAMPLE) clocks, restartable via clr.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
  parameter int unsigned BAUD       = BAUD_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV_RAW = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Free-running divider; clr restarts the count so the first tick lands DIV clocks later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
  parameter int unsigned BAUD       = BAUD_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam int unsigned TCW = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);

  localparam logic [TCW-1:0] HALF_LAST = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] FULL_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_BITS - 1);

  logic [1:0]           r_sync;
  logic                 w_rx_s;
  logic                 w_tick;
  logic                 w_div_clr;

  rx_state_e            r_state,    w_state_nxt;
  logic [TCW-1:0]       r_tick_cnt, w_tick_cnt_nxt;
  logic [BW-1:0]        r_bit_idx,  w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
  logic [DATA_BITS-1:0] r_data,     w_data_nxt;
  logic                 r_done,     w_done_nxt;
  logic                 r_ferr,     w_ferr_nxt;
  logic                 r_busy;

  baud_tick_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_div_clr),
    .tick (w_tick)
  );

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.rx};
    end
  end

  assign w_rx_s = r_sync[1];

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_data     <= w_data_nxt;
      r_done     <= w_done_nxt;
      r_ferr     <= w_ferr_nxt;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  // Next-state and datapath updates; sample points fall on tick-counter wrap.
  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_data_nxt     = r_data;
    w_done_nxt     = 1'b0;
    w_ferr_nxt     = 1'b0;
    w_div_clr      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_div_clr      = 1'b1;
          w_tick_cnt_nxt = '0;
          w_state_nxt    = START;
        end
      end

      START: begin
        if (w_tick) begin
          if (r_tick_cnt == HALF_LAST) begin
            w_tick_cnt_nxt = '0;
            if (!w_rx_s) begin
              w_bit_idx_nxt = '0;
              w_state_nxt   = DATA;
            end else begin
              // Line went back high before mid-start: glitch, not a frame.
              w_state_nxt = IDLE;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (w_tick) begin
          if (r_tick_cnt == FULL_LAST) begin
            w_tick_cnt_nxt = '0;
            w_shift_nxt    = {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == BIT_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_bit_idx_nxt = r_bit_idx + 1'b1;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (w_tick) begin
          if (r_tick_cnt == FULL_LAST) begin
            w_tick_cnt_nxt = '0;
            if (w_rx_s) begin
              w_data_nxt  = r_shift;
              w_done_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = BREAK;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end

      BREAK: begin
        // Hold off until the line recovers so a stuck-low line cannot retrigger.
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_done   = r_done;
  assign bus.rx_busy   = r_busy;
  assign bus.frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events, a monitor pops on each output strobe.
module tb_uart_rx;

  // Line rate scaled up so each frame is about 1k clocks: DIV = 6, 96 clk per bit.
  localparam int unsigned CLK_FREQ = 100_000_000;
  localparam int unsigned BAUD     = 1_000_000;
  localparam int unsigned OS       = 16;
  localparam int unsigned BIT_NS   = 960;
  localparam int unsigned BIT_FAST = 931;
  localparam int unsigned BIT_SLOW = 989;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;
  logic [7:0] last_good;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every done/err strobe must match the oldest expected event.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && (bus.rx_done || bus.frame_err)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, bus.rx_done, bus.frame_err}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("strobe_kind", {30'd0, bus.rx_done, bus.frame_err},
              e.is_err ? 32'd1 : 32'd2);
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned bns);
    bus.rx = 1'b0;
    #(bns);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      #(bns);
    end
    bus.rx = stop;
    #(bns);
  endtask

  task automatic send_good(input logic [7:0] d, input int unsigned bns);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    sb_q.push_back(e);
    last_good = d;
    send_frame(d, 1'b1, bns);
  endtask

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check(name, sb_q.size(), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    n_cmp     = 0;
    n_bad     = 0;
    last_good = 8'h00;
    rst       = 1'b0;
    bus.rx    = 1'b1;

    // Reset values.
    #23;
    check("reset_rx_data", {24'd0, bus.rx_data}, 32'h00);
    check("reset_rx_done", {31'd0, bus.rx_done}, 32'd0);
    check("reset_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
    check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    rst = 1'b1;
    #200;
    check("idle_busy", {31'd0, bus.rx_busy}, 32'd0);

    // Back-to-back ASCII bytes.
    send_good(8'h30, BIT_NS);
    send_good(8'h31, BIT_NS);
    send_good(8'h32, BIT_NS);
    wait_drain("drain_30_32");

    // All-zero and all-one data; no false start at the stop edge after 00.
    send_good(8'h00, BIT_NS);
    #(BIT_NS * 2);
    check("no_false_start_after_00", {31'd0, bus.rx_busy}, 32'd0);
    send_good(8'hFF, BIT_NS);
    wait_drain("drain_00_ff");
    #(BIT_NS);

    // Short low glitch: busy rises, then START rejects it.
    bus.rx = 1'b0;
    #150;
    check("glitch_busy_high", {31'd0, bus.rx_busy}, 32'd1);
    #50;
    bus.rx = 1'b1;
    #(BIT_NS);
    check("glitch_busy_low", {31'd0, bus.rx_busy}, 32'd0);
    send_good(8'hA5, BIT_NS);
    wait_drain("drain_a5");

    // Stop bit low, line held low: one frame_err, data held, stays in BREAK.
    e.is_err = 1'b1;
    e.data   = last_good;
    sb_q.push_back(e);
    send_frame(8'h55, 1'b0, BIT_NS);
    #(BIT_NS * 5);
    check("break_busy_held", {31'd0, bus.rx_busy}, 32'd1);
    wait_drain("drain_ferr");
    #(BIT_NS * 5);
    bus.rx = 1'b1;
    #100;
    check("break_exit_busy", {31'd0, bus.rx_busy}, 32'd0);
    check("break_data_kept", {24'd0, bus.rx_data}, 32'hA5);
    #(BIT_NS);
    send_good(8'h3C, BIT_NS);
    wait_drain("drain_3c");
    #(BIT_NS);

    // Reset during data bit 4 aborts the frame; held until the line is idle.
    fork
      send_frame(8'h96, 1'b1, BIT_NS);
      begin
        #(BIT_NS * 5 + BIT_NS / 2);
        check("midframe_busy", {31'd0, bus.rx_busy}, 32'd1);
        rst = 1'b0;
        #2;
        check("abort_rx_data", {24'd0, bus.rx_data}, 32'h00);
        check("abort_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
        check("abort_rx_done", {31'd0, bus.rx_done}, 32'd0);
        check("abort_frame_err", {31'd0, bus.frame_err}, 32'd0);
      end
    join
    #(BIT_NS);
    rst = 1'b1;
    #(BIT_NS);
    check("post_reset_busy", {31'd0, bus.rx_busy}, 32'd0);
    send_good(8'h69, BIT_NS);
    wait_drain("drain_69");
    #(BIT_NS);

    // Skewed bit time, fast then slow.
    send_good(8'hC3, BIT_FAST);
    wait_drain("drain_c3_fast");
    #(BIT_NS * 2);
    send_good(8'hC3, BIT_SLOW);
    wait_drain("drain_c3_slow");
    #(BIT_NS * 2);
    check("final_busy", {31'd0, bus.rx_busy}, 32'd0);
    check("final_rx_data", {24'd0, bus.rx_data}, 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive front end for `uart_top`. It samples the asynchronous serial input `rx` with 16x oversampling and recovers 8N1 frames: 1 start bit, 8 data bits LSB first, and 1 stop bit. Each good byte is presented on `rx_data` with a one-cycle `rx_done` strobe. The block sits between the board RX pin and the loopback/FIFO logic that feeds the transmitter.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUD`, 9600, line rate in bit/s.
- `OVERSAMPLE`, 16, ticks per bit time; must be even and ≥8.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock domain only.
- `rx`  in  1  serial line, asynchronous to `clk`; idles high.
- `rx_data`  out  8  last correctly received byte.
- `rx_done`  out  1  one-cycle pulse; `rx_data` is valid from this cycle onward.
- `rx_busy`  out  1  high while a frame is in progress (any state other than IDLE).
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- `rx` passes through a 2-FF synchronizer, reset to 1. The FSM only sees the synchronized value `rx_s`.
- Tick divider: `DIV = CLK_FREQ/(BAUD*OVERSAMPLE)`, integer floor. At the defaults this is 651, giving 10416 clk per bit. The tick is a one-cycle pulse every DIV clocks. The divider is cleared synchronously when a start is detected in IDLE.
- FSM states:
  - IDLE: `rx_busy` is 0. When `rx_s` is 0, clear the divider and the tick counter, then go to START.
  - START: count OVERSAMPLE/2 ticks. At that point, if `rx_s` is 0, clear the tick counter, clear the bit index, and go to DATA. If `rx_s` is 1, treat it as a glitch and return to IDLE with no outputs.
  - DATA: every OVERSAMPLE ticks, sample `rx_s` into the shift register (LSB first: `shift <= {rx_s, shift[7:1]}`). After the sample at bit index 7, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample `rx_s`.
    - If it is 1: `rx_data <= shift`, pulse `rx_done`, go to IDLE.
    - If it is 0: pulse `frame_err`, leave `rx_data` unchanged, go to BREAK.
  - BREAK: wait until `rx_s` is 1, then go to IDLE. This prevents a held-low line from producing repeated false starts.
- Tick counter: width `$clog2(OVERSAMPLE)`. It wraps to 0 on each sample point.
- Bit index: 3 bits, range 0..7.
- `rx_done` and `frame_err` are never asserted in the same cycle.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets a start bit that immediately follows the stop bit be detected without loss.

## Timing
- Reset values:
  - `rx_data` = 8'h00
  - `rx_done` = 0
  - `rx_busy` = 0
  - `frame_err` = 0
  - FSM in IDLE
  - synchronizer = 1
  - divider and all counters = 0
- Reset asserted mid-frame aborts the frame immediately, with no `rx_done` and no `frame_err`. After release, the block waits for a fresh falling edge.
- Synchronizer latency: 2 clk from the `rx` edge to `rx_s`.
- Sample points are at mid-bit, measured from the detected start edge:
  - start check at 8 ticks
  - data bit k at (8 + 16·(k+1)) ticks
  - stop bit at (8 + 16·9) = 152 ticks, about 9.5 bit times
- `rx_done` / `frame_err` rise on the clk after the stop-sample tick. They are 1 cycle wide.
- `rx_busy` rises on the clk after start detection. It falls in the same cycle `rx_done` is asserted, or when BREAK exits.
- Tolerated baud mismatch: ±3% cumulative over the frame.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK)
  - default `CLK_FREQ` / `BAUD` / `OVERSAMPLE` constants
  - `DATA_BITS` = 8
- Sub-module `baud_tick_gen` (params `CLK_FREQ`, `BAUD`, `OVERSAMPLE`; ports `clk`, `rst`, `clr`, `tick`). The TX path reuses it with `OVERSAMPLE` = 1.
- `uart_rx` itself contains the synchronizer, the FSM, the tick counter, the bit index, and the shift register.

## Test plan
- Bench drives bytes 8'h30, 8'h31, 8'h32 at 104166 ns/bit, each waiting on `rx_done` before the next. Required: three `rx_done` pulses with `rx_data` = 30, 31, 32 in order, and `frame_err` never asserted.
- Bytes 8'h00 and 8'hFF (all-low and all-high data) -> `rx_done` with the exact value. After 8'h00, no false start occurs at the stop edge.
- 2 µs low glitch on an idle line -> `rx_busy` pulses, then the block returns to IDLE. No `rx_done` and no `frame_err`. A subsequent 8'hA5 is received correctly.
- Frame 8'h55 with stop bit driven 0, line held low 1 ms, then high -> a single `frame_err` pulse, `rx_data` keeps the previous byte, FSM stays in BREAK until the line goes high. The next 8'h3C is received correctly.
- `rst` asserted low during data bit 4 of 8'h96 -> all outputs return to reset values immediately and that byte never gets `rx_done`. After release, 8'h69 is received.
- Bit time skewed ±3% (101041 ns and 107291 ns/bit) sending 8'hC3 -> received correctly in both cases.
